// File: rtl/local_flit_injector.sv
// local_flit_injector: turns (dest, len) descriptors plus payload words into head/body/tail flits
// on one round-robin allocated VC per packet, gated by the router's per-VC on/off flow control.
module local_flit_injector #(
    parameter int VC_NUM       = 2,
    parameter int PAYLOAD_W    = 29,
    parameter int DEST_W       = 4,
    parameter int MAX_PKT_LEN  = 8,
    parameter int DESC_DEPTH   = 4,
    localparam int VC_W        = $clog2(VC_NUM),
    localparam int FLIT_W      = 2 + VC_W + PAYLOAD_W,
    localparam int LEN_W       = $clog2(MAX_PKT_LEN + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 pkt_valid_i,
    output logic                 pkt_ready_o,
    input  logic [DEST_W-1:0]    pkt_dest_x_i,
    input  logic [DEST_W-1:0]    pkt_dest_y_i,
    input  logic [LEN_W-1:0]     pkt_len_i,
    input  logic                 pld_valid_i,
    output logic                 pld_ready_o,
    input  logic [PAYLOAD_W-1:0] pld_data_i,
    output logic [FLIT_W-1:0]    data_o,
    output logic                 valid_flit_o,
    input  logic [VC_NUM-1:0]    on_off_i,
    input  logic [VC_NUM-1:0]    vc_allocatable_i,
    output logic                 busy_o,
    output logic                 pkt_sent_o,
    output logic                 err_len_o
);
    localparam int PTR_W = $clog2(DESC_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_VA, S_HEAD, S_BODY} state_t;

    state_t               r_state, w_next;
    logic [DEST_W-1:0]    r_fx [DESC_DEPTH];
    logic [DEST_W-1:0]    r_fy [DESC_DEPTH];
    logic [LEN_W-1:0]     r_fl [DESC_DEPTH];
    logic [PTR_W-1:0]     r_wp, r_rp;
    logic [PTR_W:0]       r_cnt;
    logic [DEST_W-1:0]    r_dx, r_dy;
    logic [LEN_W-1:0]     r_len, r_rem;
    logic [VC_W-1:0]      r_vc, r_rr, w_gnt, w_idx, w_rr_next;
    logic [FLIT_W-1:0]    r_data;
    logic                 r_valid, r_sent, r_err;
    logic                 w_any, w_bad, w_push, w_pop, w_empty, w_grant;
    logic                 w_send_head, w_send_body, w_on, w_last;
    logic [PAYLOAD_W-1:0] w_head_pld;

    assign w_empty      = r_cnt == '0;
    assign pkt_ready_o  = r_cnt != (PTR_W+1)'(DESC_DEPTH);
    assign w_bad        = pkt_len_i == '0 || pkt_len_i > LEN_W'(MAX_PKT_LEN);
    assign w_push       = pkt_valid_i && pkt_ready_o && !w_bad;
    assign w_on         = on_off_i[r_vc];
    assign w_last       = r_rem == LEN_W'(1);
    assign w_head_pld   = {r_dx, r_dy, {(PAYLOAD_W - 2*DEST_W){1'b0}}};
    assign w_rr_next    = VC_W'((int'(w_gnt) + 1) % VC_NUM);
    assign busy_o       = r_state != S_IDLE || !w_empty;
    assign data_o       = r_data;
    assign valid_flit_o = r_valid;
    assign pkt_sent_o   = r_sent;
    assign err_len_o    = r_err;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fx[r_wp] <= pkt_dest_x_i;
            r_fy[r_wp] <= pkt_dest_y_i;
            r_fl[r_wp] <= pkt_len_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) r_wp <= r_wp + 1'b1;
            if (w_pop) r_rp <= r_rp + 1'b1;
            r_cnt <= r_cnt + (PTR_W+1)'(w_push) - (PTR_W+1)'(w_pop);
        end
    end

    // Scan downwards so the lowest offset from the RR pointer wins
    always_comb begin
        w_any = 1'b0;
        w_gnt = '0;
        w_idx = '0;
        for (int i = VC_NUM - 1; i >= 0; i--) begin
            w_idx = VC_W'((int'(r_rr) + i) % VC_NUM);
            if (vc_allocatable_i[w_idx]) begin
                w_any = 1'b1;
                w_gnt = w_idx;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  w_next = w_empty ? S_IDLE : S_VA;
            S_VA:    w_next = w_any ? S_HEAD : S_VA;
            S_HEAD:  w_next = !w_on ? S_HEAD : (r_len == LEN_W'(1)) ? S_IDLE : S_BODY;
            S_BODY:  w_next = (w_send_body && w_last) ? S_IDLE : S_BODY;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_pop       = r_state == S_IDLE && !w_empty;
        w_grant     = r_state == S_VA && w_any;
        w_send_head = r_state == S_HEAD && w_on;
        pld_ready_o = r_state == S_BODY && w_on;
        w_send_body = pld_ready_o && pld_valid_i;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data  <= '0;
            r_valid <= 1'b0;
            r_sent  <= 1'b0;
            r_err   <= 1'b0;
            r_dx    <= '0;
            r_dy    <= '0;
            r_len   <= '0;
            r_rem   <= '0;
            r_vc    <= '0;
            r_rr    <= '0;
        end else begin
            r_valid <= w_send_head || w_send_body;
            r_sent  <= (w_send_head && r_len == LEN_W'(1)) || (w_send_body && w_last);
            r_err   <= pkt_valid_i && pkt_ready_o && w_bad;
            if (w_pop) begin
                r_dx  <= r_fx[r_rp];
                r_dy  <= r_fy[r_rp];
                r_len <= r_fl[r_rp];
            end
            if (w_grant) begin
                r_vc <= w_gnt;
                r_rr <= w_rr_next;
            end
            if (w_send_head) begin
                r_data <= {(r_len == LEN_W'(1)) ? 2'b11 : 2'b00, r_vc, w_head_pld};
                r_rem  <= r_len - LEN_W'(1);
            end else if (w_send_body) begin
                r_data <= {w_last ? 2'b10 : 2'b01, r_vc, pld_data_i};
                r_rem  <= r_rem - LEN_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_local_flit_injector.sv
// tb_local_flit_injector: directed stimulus with a flit scoreboard checked by an independent monitor.
module tb_local_flit_injector;
    logic        clk, rst;
    logic        pkt_valid_i, pkt_ready_o;
    logic [3:0]  pkt_dest_x_i, pkt_dest_y_i, pkt_len_i;
    logic        pld_valid_i, pld_ready_o;
    logic [28:0] pld_data_i;
    logic [31:0] data_o;
    logic        valid_flit_o;
    logic [1:0]  on_off_i, vc_allocatable_i;
    logic        busy_o, pkt_sent_o, err_len_o;

    logic [32:0] exp_q[$];
    logic [28:0] pld_q[$];
    int          checks = 0;
    int          failures = 0;

    local_flit_injector #(
        .VC_NUM(2), .PAYLOAD_W(29), .DEST_W(4), .MAX_PKT_LEN(8), .DESC_DEPTH(4)
    ) dut (
        .clk(clk), .rst(rst),
        .pkt_valid_i(pkt_valid_i), .pkt_ready_o(pkt_ready_o),
        .pkt_dest_x_i(pkt_dest_x_i), .pkt_dest_y_i(pkt_dest_y_i), .pkt_len_i(pkt_len_i),
        .pld_valid_i(pld_valid_i), .pld_ready_o(pld_ready_o), .pld_data_i(pld_data_i),
        .data_o(data_o), .valid_flit_o(valid_flit_o),
        .on_off_i(on_off_i), .vc_allocatable_i(vc_allocatable_i),
        .busy_o(busy_o), .pkt_sent_o(pkt_sent_o), .err_len_o(err_len_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] fhead(input logic [3:0] dx, input logic [3:0] dy, input logic vc, input int len);
        return {(len == 1) ? 2'b11 : 2'b00, vc, dx, dy, 21'b0};
    endfunction

    function automatic logic [31:0] fbody(input logic [1:0] t, input logic vc, input logic [28:0] d);
        return {t, vc, d};
    endfunction

    task automatic expect_flit(input logic sent, input logic [31:0] f);
        exp_q.push_back({sent, f});
    endtask

    task automatic push(input logic [3:0] dx, input logic [3:0] dy, input logic [3:0] len);
        pkt_dest_x_i = dx;
        pkt_dest_y_i = dy;
        pkt_len_i    = len;
        pkt_valid_i  = 1'b1;
        @(posedge clk);
        #1;
        pkt_valid_i  = 1'b0;
    endtask

    task automatic wait_valid(input int limit, output int n);
        n = 0;
        while (n < limit) begin
            @(negedge clk);
            n++;
            if (valid_flit_o) break;
        end
        if (!valid_flit_o) begin
            checks++;
            failures++;
            $display("FAIL wait_valid: no flit within %0d cycles", limit);
        end
    endtask

    task automatic wait_idle();
        int k;
        for (k = 0; k < 300; k++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !busy_o) break;
        end
        if (k == 300) begin
            checks++;
            failures++;
            $display("FAIL wait_idle: %0d flits outstanding, busy=%0b", exp_q.size(), busy_o);
        end
    endtask

    initial begin : monitor
        logic [32:0] e;
        forever begin
            @(negedge clk);
            if (!rst && valid_flit_o) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_flit: got %0h expected none", data_o);
                end else begin
                    e = exp_q.pop_front();
                    chk("flit_data", 64'(data_o), 64'(e[31:0]));
                    chk("flit_sent", 64'(pkt_sent_o), 64'(e[32]));
                end
            end
        end
    end

    initial begin : feeder
        bit hs;
        pld_valid_i = 1'b0;
        pld_data_i  = '0;
        forever begin
            @(negedge clk);
            hs = pld_valid_i && pld_ready_o;
            @(posedge clk);
            #1;
            if (hs && pld_q.size() > 0) void'(pld_q.pop_front());
            pld_valid_i = pld_q.size() > 0;
            pld_data_i  = (pld_q.size() > 0) ? pld_q[0] : '0;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int n, run;
        rst = 1'b1;
        pkt_valid_i = 1'b0;
        pkt_dest_x_i = '0;
        pkt_dest_y_i = '0;
        pkt_len_i = '0;
        on_off_i = 2'b11;
        vc_allocatable_i = 2'b01;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_data", 64'(data_o), 0);
        chk("rst_valid", 64'(valid_flit_o), 0);
        chk("rst_sent", 64'(pkt_sent_o), 0);
        chk("rst_err", 64'(err_len_o), 0);
        chk("rst_pkt_ready", 64'(pkt_ready_o), 1);
        chk("rst_pld_ready", 64'(pld_ready_o), 0);
        chk("rst_busy", 64'(busy_o), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);

        // single-flit packet, earliest path
        expect_flit(1'b1, 32'hC460_0000);
        push(4'd2, 4'd3, 4'd1);
        wait_valid(20, n);
        chk("headtail_latency", 64'(n), 4);
        wait_idle();

        // four-flit packet on consecutive cycles
        pld_q.push_back(29'h1234567);
        pld_q.push_back(29'h0ABCDEF);
        pld_q.push_back(29'h1FFFFFF);
        expect_flit(1'b0, fhead(4'd5, 4'd6, 1'b0, 4));
        expect_flit(1'b0, fbody(2'b01, 1'b0, 29'h1234567));
        expect_flit(1'b0, fbody(2'b01, 1'b0, 29'h0ABCDEF));
        expect_flit(1'b1, fbody(2'b10, 1'b0, 29'h1FFFFFF));
        push(4'd5, 4'd6, 4'd4);
        wait_valid(20, n);
        run = 1;
        repeat (3) begin
            @(negedge clk);
            if (valid_flit_o) run++;
        end
        chk("back_to_back_run", 64'(run), 4);
        wait_idle();

        // on/off stall for three cycles mid-packet
        for (int i = 0; i < 4; i++) pld_q.push_back(29'h0100000 + 29'(i));
        expect_flit(1'b0, fhead(4'd1, 4'd1, 1'b0, 5));
        for (int i = 0; i < 3; i++) expect_flit(1'b0, fbody(2'b01, 1'b0, 29'h0100000 + 29'(i)));
        expect_flit(1'b1, fbody(2'b10, 1'b0, 29'h0100003));
        push(4'd1, 4'd1, 4'd5);
        wait_valid(20, n);
        @(posedge clk);
        #1 on_off_i = 2'b00;
        @(negedge clk);
        chk("stall_last_before", 64'(valid_flit_o), 1);
        chk("stall_pld_ready0", 64'(pld_ready_o), 0);
        @(negedge clk);
        chk("stall_valid1", 64'(valid_flit_o), 0);
        chk("stall_pld_ready1", 64'(pld_ready_o), 0);
        @(negedge clk);
        chk("stall_valid2", 64'(valid_flit_o), 0);
        chk("stall_pld_ready2", 64'(pld_ready_o), 0);
        @(posedge clk);
        #1 on_off_i = 2'b11;
        @(negedge clk);
        chk("stall_valid3", 64'(valid_flit_o), 0);
        chk("resume_pld_ready", 64'(pld_ready_o), 1);
        wait_idle();

        // reset during BODY abandons the packet
        for (int i = 0; i < 5; i++) pld_q.push_back(29'h0200000 + 29'(i));
        expect_flit(1'b0, fhead(4'd7, 4'd8, 1'b0, 6));
        expect_flit(1'b0, fbody(2'b01, 1'b0, 29'h0200000));
        push(4'd7, 4'd8, 4'd6);
        wait_valid(20, n);
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        chk("midrst_valid", 64'(valid_flit_o), 0);
        chk("midrst_data", 64'(data_o), 0);
        chk("midrst_sent", 64'(pkt_sent_o), 0);
        chk("midrst_busy", 64'(busy_o), 0);
        chk("midrst_pkt_ready", 64'(pkt_ready_o), 1);
        chk("midrst_pld_ready", 64'(pld_ready_o), 0);
        @(posedge clk);
        #2 pld_q.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);

        // round robin after reset: VC0 then VC1, then only VC1 free
        vc_allocatable_i = 2'b11;
        pld_q.push_back(29'h0000AAA);
        pld_q.push_back(29'h0000BBB);
        expect_flit(1'b0, fhead(4'd3, 4'd4, 1'b0, 2));
        expect_flit(1'b1, fbody(2'b10, 1'b0, 29'h0000AAA));
        expect_flit(1'b0, fhead(4'd9, 4'd10, 1'b1, 2));
        expect_flit(1'b1, fbody(2'b10, 1'b1, 29'h0000BBB));
        push(4'd3, 4'd4, 4'd2);
        push(4'd9, 4'd10, 4'd2);
        wait_idle();
        vc_allocatable_i = 2'b10;
        expect_flit(1'b1, fhead(4'd15, 4'd0, 1'b1, 1));
        push(4'd15, 4'd0, 4'd1);
        wait_idle();

        // length errors and FIFO full, with the FSM held in VA
        vc_allocatable_i = 2'b00;
        push(4'd1, 4'd2, 4'd1);
        repeat (3) @(negedge clk);
        chk("va_stuck_busy", 64'(busy_o), 1);
        push(4'd0, 4'd0, 4'd0);
        @(negedge clk);
        chk("err_len0_pulse", 64'(err_len_o), 1);
        @(negedge clk);
        chk("err_len0_clear", 64'(err_len_o), 0);
        push(4'd0, 4'd0, 4'd9);
        @(negedge clk);
        chk("err_len9_pulse", 64'(err_len_o), 1);
        @(negedge clk);
        chk("err_len9_clear", 64'(err_len_o), 0);
        push(4'd2, 4'd2, 4'd1);
        push(4'd3, 4'd3, 4'd1);
        push(4'd4, 4'd4, 4'd1);
        @(negedge clk);
        chk("fifo_ready_at3", 64'(pkt_ready_o), 1);
        push(4'd5, 4'd5, 4'd1);
        @(negedge clk);
        chk("fifo_full_ready", 64'(pkt_ready_o), 0);
        pkt_dest_x_i = 4'd6;
        pkt_len_i = 4'd1;
        pkt_valid_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("fifo_full_stall", 64'(pkt_ready_o), 0);
        chk("fifo_full_no_err", 64'(err_len_o), 0);
        #1 pkt_valid_i = 1'b0;
        expect_flit(1'b1, fhead(4'd1, 4'd2, 1'b0, 1));
        expect_flit(1'b1, fhead(4'd2, 4'd2, 1'b1, 1));
        expect_flit(1'b1, fhead(4'd3, 4'd3, 1'b0, 1));
        expect_flit(1'b1, fhead(4'd4, 4'd4, 1'b1, 1));
        expect_flit(1'b1, fhead(4'd5, 4'd5, 1'b0, 1));
        vc_allocatable_i = 2'b11;
        wait_idle();
        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 64'(exp_q.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
